// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences the shared datapath per instruction.
// Ports: clk, rst (async, active-high); op[5:0], zero, mem_ready in;
//   mem_req, memwrite, iord, irwrite, pcen, regwrite, regdst, memtoreg,
//   alusrca, alusrcb[1:0], aluop[1:0], pcsrc[1:0], bus_err, exc out.
// MEM_TIMEOUT: max stall cycles per memory access (0 disables the check).
// Optional macro MCTRL_TRAP_EN: illegal opcodes enter a sticky TRAP state.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       memwrite,
  output logic       iord,
  output logic       irwrite,
  output logic       pcen,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [1:0] pcsrc,
  output logic       bus_err,
  output logic       exc
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
    S_TRAP   = 4'd12,
    S_HALT   = 4'd13
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RT   = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam int CW =
    (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_wait;
  logic [CW-1:0] w_wait_nxt;
  logic          r_berr;
  logic          w_timeout;
  logic          w_ready;

  logic       w_req;
  logic       w_mwr;
  logic       w_iord;
  logic       w_irw;
  logic       w_pcw;
  logic       w_br;
  logic       w_rw;
  logic       w_rdst;
  logic       w_m2r;
  logic       w_srca;
  logic [1:0] w_srcb;
  logic [1:0] w_aluop;
  logic [1:0] w_pcsrc;

  // Once the stall budget is spent, a late mem_ready must not complete
  // the access: the FSM is already committed to HALT.
  assign w_timeout = (MEM_TIMEOUT != 0) &&
                     (r_wait == CW'(MEM_TIMEOUT));
  assign w_ready   = mem_ready & ~w_timeout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_wait  <= '0;
      r_berr  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_wait  <= w_wait_nxt;
      if (w_timeout) r_berr <= 1'b1;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH: begin
        if (w_timeout)    w_next = S_HALT;
        else if (w_ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        unique case (1'b1)
          (op == OP_LW),
          (op == OP_SW):   w_next = S_MEMADR;
          (op == OP_RT):   w_next = S_EXEC;
          (op == OP_BEQ):  w_next = S_BRANCH;
          (op == OP_ADDI): w_next = S_ADDIEX;
          (op == OP_J):    w_next = S_JUMP;
`ifdef MCTRL_TRAP_EN
          default:         w_next = S_TRAP;
`else
          default:         w_next = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        w_next = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        if (w_timeout)    w_next = S_HALT;
        else if (w_ready) w_next = S_MEMWB;
      end
      S_MEMWR: begin
        if (w_timeout)    w_next = S_HALT;
        else if (w_ready) w_next = S_FETCH;
      end
      S_MEMWB:  w_next = S_FETCH;
      S_EXEC:   w_next = S_ALUWB;
      S_ALUWB:  w_next = S_FETCH;
      S_BRANCH: w_next = S_FETCH;
      S_ADDIEX: w_next = S_ADDIWB;
      S_ADDIWB: w_next = S_FETCH;
      S_JUMP:   w_next = S_FETCH;
`ifdef MCTRL_TRAP_EN
      S_TRAP:   w_next = S_TRAP;
`else
      S_TRAP:   w_next = S_FETCH;
`endif
      S_HALT:   w_next = S_HALT;
      default:  w_next = S_FETCH;
    endcase
  end

  always_comb begin
    w_wait_nxt = '0;
    if (w_req && !mem_ready && (w_next == r_state))
      w_wait_nxt = (&r_wait) ? r_wait : r_wait + CW'(1);
  end

  always_comb begin
    w_req   = 1'b0;
    w_mwr   = 1'b0;
    w_iord  = 1'b0;
    w_irw   = 1'b0;
    w_pcw   = 1'b0;
    w_br    = 1'b0;
    w_rw    = 1'b0;
    w_rdst  = 1'b0;
    w_m2r   = 1'b0;
    w_srca  = 1'b0;
    w_srcb  = 2'b00;
    w_aluop = 2'b00;
    w_pcsrc = 2'b00;
    case (r_state)
      S_FETCH: begin
        w_req  = 1'b1;
        w_srcb = 2'b01;
        w_irw  = w_ready;
        w_pcw  = w_ready;
      end
      S_DECODE: w_srcb = 2'b11;
      S_MEMADR: begin
        w_srca = 1'b1;
        w_srcb = 2'b10;
      end
      S_MEMRD: begin
        w_req  = 1'b1;
        w_iord = 1'b1;
      end
      S_MEMWB: begin
        w_rw  = 1'b1;
        w_m2r = 1'b1;
      end
      S_MEMWR: begin
        w_req  = 1'b1;
        w_mwr  = 1'b1;
        w_iord = 1'b1;
      end
      S_EXEC: begin
        w_srca  = 1'b1;
        w_aluop = 2'b10;
      end
      S_ALUWB: begin
        w_rw   = 1'b1;
        w_rdst = 1'b1;
      end
      S_BRANCH: begin
        w_srca  = 1'b1;
        w_aluop = 2'b01;
        w_pcsrc = 2'b01;
        w_br    = 1'b1;
      end
      S_ADDIEX: begin
        w_srca = 1'b1;
        w_srcb = 2'b10;
      end
      S_ADDIWB: w_rw = 1'b1;
      S_JUMP: begin
        w_pcsrc = 2'b10;
        w_pcw   = 1'b1;
      end
      default: ;
    endcase
  end

  // Gating with rst drops an in-flight request the moment reset rises.
  assign mem_req  = w_req  & ~rst;
  assign memwrite = w_mwr  & ~rst;
  assign iord     = w_iord & ~rst;
  assign irwrite  = w_irw  & ~rst;
  assign pcen     = (w_pcw | (w_br & zero)) & ~rst;
  assign regwrite = w_rw   & ~rst;
  assign regdst   = w_rdst & ~rst;
  assign memtoreg = w_m2r  & ~rst;
  assign alusrca  = w_srca & ~rst;
  assign alusrcb  = w_srcb  & {2{~rst}};
  assign aluop    = w_aluop & {2{~rst}};
  assign pcsrc    = w_pcsrc & {2{~rst}};
  assign bus_err  = r_berr;

`ifdef MCTRL_TRAP_EN
  logic r_exc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    r_exc <= 1'b0;
    else if (r_state == S_TRAP) r_exc <= 1'b1;
  end

  assign exc = r_exc;
`else
  assign exc = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-opcode step-sequence model,
// per-cycle compare on the falling edge, plus literal spot checks.
module tb_multicycle_ctrl;

  localparam int TO = 4;
`ifdef MCTRL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] RT   = 6'b000000;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] JMP  = 6'b000010;
  localparam logic [5:0] BAD  = 6'b111111;

  // instruction steps (names, not hardware encodings)
  localparam int P_F   = 20;
  localparam int P_D   = 21;
  localparam int P_MA  = 22;
  localparam int P_MR  = 23;
  localparam int P_MWB = 24;
  localparam int P_MW  = 25;
  localparam int P_EX  = 26;
  localparam int P_AW  = 27;
  localparam int P_BR  = 28;
  localparam int P_AE  = 29;
  localparam int P_AWB = 30;
  localparam int P_J   = 31;
  localparam int P_TR  = 32;
  localparam int P_H   = 33;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op;
  logic       zero;
  logic       mem_ready;
  logic       mem_req;
  logic       memwrite;
  logic       iord;
  logic       irwrite;
  logic       pcen;
  logic       regwrite;
  logic       regdst;
  logic       memtoreg;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] aluop;
  logic [1:0] pcsrc;
  logic       bus_err;
  logic       exc;

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  int m_step = P_F;
  int m_wait = 0;
  bit m_berr = 1'b0;
  bit m_exc  = 1'b0;
  int m_q[$];

  multicycle_ctrl #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .op(op), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req),
    .memwrite(memwrite), .iord(iord), .irwrite(irwrite),
    .pcen(pcen), .regwrite(regwrite), .regdst(regdst),
    .memtoreg(memtoreg), .alusrca(alusrca),
    .alusrcb(alusrcb), .aluop(aluop), .pcsrc(pcsrc),
    .bus_err(bus_err), .exc(exc)
  );

  always #5 clk = ~clk;

  logic [17:0] dut_v;
  assign dut_v = {mem_req, memwrite, iord, irwrite, pcen,
                  regwrite, regdst, memtoreg, alusrca,
                  alusrcb, aluop, pcsrc, bus_err, exc};

  task automatic chk(input string nm,
                     input logic [17:0] got,
                     input logic [17:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h want %h",
               nm, $time, got, exp);
    end
  endtask

  // Expected control word for one step of an instruction.
  function automatic logic [17:0] mdl(input int s,
                                      input logic rdy,
                                      input logic z,
                                      input logic be,
                                      input logic ex);
    logic mr, mw, io, irw, pce, rw, rd, m2r, sa;
    logic [1:0] sb, ao, ps;
    {mr, mw, io, irw, pce, rw, rd, m2r, sa} = '0;
    sb = 2'b00;
    ao = 2'b00;
    ps = 2'b00;
    case (s)
      P_F:   begin mr = 1; sb = 2'b01; irw = rdy; pce = rdy; end
      P_D:   sb = 2'b11;
      P_MA:  begin sa = 1; sb = 2'b10; end
      P_MR:  begin mr = 1; io = 1; end
      P_MWB: begin rw = 1; m2r = 1; end
      P_MW:  begin mr = 1; mw = 1; io = 1; end
      P_EX:  begin sa = 1; ao = 2'b10; end
      P_AW:  begin rw = 1; rd = 1; end
      P_BR:  begin sa = 1; ao = 2'b01; ps = 2'b01; pce = z; end
      P_AE:  begin sa = 1; sb = 2'b10; end
      P_AWB: rw = 1;
      P_J:   begin ps = 2'b10; pce = 1; end
      default: ;
    endcase
    return {mr, mw, io, irw, pce, rw, rd, m2r, sa,
            sb, ao, ps, be, ex};
  endfunction

  task automatic load_seq(input logic [5:0] o);
    m_q.delete();
    m_q.push_back(P_D);
    case (o)
      LW:   begin m_q.push_back(P_MA); m_q.push_back(P_MR);
                  m_q.push_back(P_MWB); end
      SW:   begin m_q.push_back(P_MA); m_q.push_back(P_MW); end
      RT:   begin m_q.push_back(P_EX); m_q.push_back(P_AW); end
      BEQ:  m_q.push_back(P_BR);
      ADDI: begin m_q.push_back(P_AE); m_q.push_back(P_AWB); end
      JMP:  m_q.push_back(P_J);
      default: if (TRAP) m_q.push_back(P_TR);
    endcase
  endtask

  task automatic advance();
    if (m_step == P_F) load_seq(op);
    if (m_q.size() == 0) m_step = P_F;
    else m_step = m_q.pop_front();
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_step = P_F;
      m_wait = 0;
      m_berr = 1'b0;
      m_exc  = 1'b0;
      m_q.delete();
    end else if (m_step inside {P_F, P_MR, P_MW}) begin
      if (TO != 0 && m_wait == TO) begin
        m_step = P_H;
        m_berr = 1'b1;
        m_wait = 0;
      end else if (mem_ready) begin
        m_wait = 0;
        advance();
      end else begin
        m_wait++;
      end
    end else if (m_step == P_TR) begin
      m_exc = 1'b1;
    end else if (m_step != P_H) begin
      advance();
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [17:0] e;
      logic rdy;
      rdy = mem_ready & ~(TO != 0 && m_wait == TO);
      e = rst ? '0 : mdl(m_step, rdy, zero, m_berr, m_exc);
      chk("cycle", dut_v, e);
    end
  end

  task automatic run(input logic [5:0] o,
                     input logic r, input logic z);
    op = o;
    mem_ready = r;
    zero = z;
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic [5:0] o,
                     input logic r, input logic z);
    run(o, r, z);
    adv();
  endtask

  task automatic do_rst();
    rst = 1'b1;
    adv();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: sim did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    op = RT;
    zero = 1'b0;
    mem_ready = 1'b0;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // R-type, zero-wait memory
    run(RT, 1, 0);
    chk("fetch_word", dut_v, 18'b1_0_0_1_1_0_0_0_0_01_00_00_0_0);
    adv();
    run(RT, 1, 0);
    chk("dec_srcb", 18'(alusrcb), 18'(2'b11));
    adv();
    run(RT, 1, 0);
    chk("ex_aluop", 18'(aluop), 18'(2'b10));
    adv();
    run(RT, 1, 0);
    chk("aw_rw_rd", 18'({regwrite, regdst}), 18'(2'b11));
    adv();

    // LW with 3 stall cycles in MEMRD
    cyc(LW, 1, 0);
    cyc(LW, 1, 0);
    cyc(LW, 1, 0);
    repeat (3) begin
      run(LW, 0, 0);
      chk("mr_req_iord", 18'({mem_req, iord}), 18'(2'b11));
      adv();
    end
    run(LW, 1, 0);
    chk("mr_done", 18'({mem_req, iord}), 18'(2'b11));
    adv();
    run(LW, 0, 0);
    chk("mwb", 18'({regwrite, regdst, memtoreg}),
        18'(3'b101));
    adv();

    // BEQ taken, then not taken
    cyc(BEQ, 1, 1);
    cyc(BEQ, 1, 1);
    run(BEQ, 1, 1);
    chk("br_taken", 18'({pcen, pcsrc}), 18'(3'b101));
    adv();
    cyc(BEQ, 1, 0);
    cyc(BEQ, 1, 0);
    run(BEQ, 1, 0);
    chk("br_not", 18'({pcen, pcsrc}), 18'(3'b001));
    adv();

    // SW (fetch right after branch)
    run(SW, 1, 0);
    chk("after_br", 18'(mem_req), 18'(1'b1));
    adv();
    cyc(SW, 1, 0);
    cyc(SW, 1, 0);
    run(SW, 1, 0);
    chk("mw_strobe", 18'({mem_req, memwrite, iord}),
        18'(3'b111));
    adv();

    // ADDI and J
    cyc(ADDI, 1, 0);
    cyc(ADDI, 1, 0);
    cyc(ADDI, 1, 0);
    run(ADDI, 1, 0);
    chk("addi_wb", 18'({regwrite, regdst}), 18'(2'b10));
    adv();
    cyc(JMP, 1, 0);
    cyc(JMP, 1, 0);
    run(JMP, 1, 0);
    chk("jump", 18'({pcen, pcsrc}), 18'(3'b110));
    adv();

    // reset in the middle of a stalled store
    cyc(SW, 1, 0);
    cyc(SW, 1, 0);
    cyc(SW, 1, 0);
    run(SW, 0, 0);
    chk("mw_pre_rst", 18'(memwrite), 18'(1'b1));
    #2;
    rst = 1'b1;
    #1;
    chk("mw_async_drop", 18'({mem_req, memwrite}), 18'(2'b00));
    adv();
    rst = 1'b0;
    run(RT, 1, 0);
    chk("post_rst", 18'({mem_req, bus_err}), 18'(2'b10));
    adv();
    cyc(RT, 1, 0);
    cyc(RT, 1, 0);
    cyc(RT, 1, 0);

    // illegal opcode
    cyc(BAD, 1, 0);
    cyc(BAD, 1, 0);
`ifdef MCTRL_TRAP_EN
    run(BAD, 1, 0);
    chk("trap_quiet", 18'({mem_req, regwrite, memwrite}),
        18'(3'b000));
    adv();
    run(BAD, 1, 0);
    chk("trap_exc", 18'({exc, mem_req}), 18'(2'b10));
    adv();
    run(BAD, 1, 0);
    chk("trap_sticky", 18'(exc), 18'(1'b1));
    adv();
`else
    run(BAD, 1, 0);
    chk("nop_refetch", 18'({mem_req, regwrite, memwrite, exc}),
        18'(4'b1000));
    adv();
`endif
    do_rst();

    // bus timeout in FETCH
    run(RT, 0, 0);
    chk("to_wait", 18'({mem_req, bus_err}), 18'(2'b10));
    adv();
    repeat (3) cyc(RT, 0, 0);
    run(RT, 1, 0);
    chk("to_ignore_rdy", 18'({mem_req, irwrite, pcen}),
        18'(3'b100));
    adv();
    repeat (3) begin
      run(RT, 1, 0);
      chk("halt", 18'({mem_req, bus_err}), 18'(2'b01));
      adv();
    end
    do_rst();
    run(RT, 1, 0);
    chk("berr_clr", 18'({mem_req, bus_err}), 18'(2'b10));
    adv();

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
